// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED panel constants and loader state type
// Used by the frame buffer and by the panel scan/BCM driver.
package led_pkg;

  localparam int PANEL_W   = 64;
  localparam int PANEL_H   = 64;
  localparam int SCAN_ROWS = 32;
  localparam int PIXEL_W   = 24;
  localparam int ADDR_W    = 11;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    FULL    = 2'd1,
    PENDING = 2'd2
  } loader_state_t;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
// Ports:
//   i_clk, i_reset          clock, async active-high reset (read register only)
//   i_wr_en/addr/data       write port
//   i_rd_addr               read address, sampled every cycle
//   o_rd_data               read data, one cycle after i_rd_addr
module sdp_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 24
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never cleared; only the output register has a reset value.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_data <= '0;
    end else begin
      o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - double-buffered RGB888 pixel store for a HUB75 panel
// Ports:
//   i_clk, i_reset      clock, async active-high reset
//   i_address           driver read address {row, x}, row in the top half
//   o_data0, o_data1    front-bank pixels (row, x) and (row + HEIGHT/2, x)
//   i_wr_valid/o_wr_ready/i_wr_data/i_wr_sof   host pixel stream into back bank
//   i_commit            back bank complete, request swap
//   o_swap_pending      commit accepted, swap not yet taken
//   o_swap              one-cycle pulse in the cycle the banks exchange
module frame_buffer
  import led_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int HEIGHT  = 64,
  parameter int PIXEL_W = 24
) (
  input  logic                                       i_clk,
  input  logic                                       i_reset,
  input  logic [$clog2(HEIGHT/2)+$clog2(WIDTH)-1:0]  i_address,
  output logic [PIXEL_W-1:0]                         o_data0,
  output logic [PIXEL_W-1:0]                         o_data1,
  input  logic                                       i_wr_valid,
  output logic                                       o_wr_ready,
  input  logic [PIXEL_W-1:0]                         i_wr_data,
  input  logic                                       i_wr_sof,
  input  logic                                       i_commit,
  output logic                                       o_swap_pending,
  output logic                                       o_swap
);

  localparam int X_W   = $clog2(WIDTH);
  localparam int ROWS  = HEIGHT / 2;
  localparam int ROW_W = $clog2(ROWS);
  localparam int AW    = ROW_W + X_W;          // per-bank address width
  localparam int FRAME = WIDTH * HEIGHT;
  localparam int IDX_W = AW + 1;               // pixel index across both halves
  localparam int WP_W  = IDX_W + 1;            // wp must reach FRAME itself

  loader_state_t   state, state_next;
  logic [WP_W-1:0] wp, wp_next;
  logic            front, front_next;
  logic            ready_q, ready_next;
  logic [ROW_W-1:0] row_prev;

  logic             accept;
  logic             boundary;
  logic [IDX_W-1:0] wr_idx;
  logic [AW:0]      wr_addr;
  logic [AW:0]      rd_addr;
  logic             swap_now;

  assign accept   = i_wr_valid && ready_q;
  assign boundary = (row_prev == ROW_W'(ROWS - 1)) &&
                    (i_address[AW-1:X_W] == '0);

  // sof restarts the frame: the flagged pixel always lands at index 0.
  assign wr_idx  = i_wr_sof ? '0 : wp[IDX_W-1:0];
  assign wr_addr = {~front, wr_idx[AW-1:0]};

  always_comb begin
    state_next = state;
    wp_next    = wp;
    front_next = front;
    swap_now   = 1'b0;

    if (accept) begin
      wp_next = {1'b0, wr_idx} + WP_W'(1);
    end

    case (state)
      LOAD: begin
        // A pixel accepted alongside a commit is still written; the commit wins the state.
        if (i_commit) begin
          state_next = PENDING;
        end else if (wp_next == WP_W'(FRAME)) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (i_commit) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (boundary) begin
          swap_now   = 1'b1;
          front_next = ~front;
          wp_next    = '0;
          state_next = LOAD;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase

    ready_next = (state_next == LOAD);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= LOAD;
      wp       <= '0;
      front    <= 1'b0;
      ready_q  <= 1'b1;
      row_prev <= '0;
    end else begin
      state    <= state_next;
      wp       <= wp_next;
      front    <= front_next;
      ready_q  <= ready_next;
      row_prev <= i_address[AW-1:X_W];
    end
  end

  // The read issued in the swap cycle is the first pixel of the new frame,
  // so it must already target the bank that becomes front at this edge.
  assign rd_addr = {front ^ swap_now, i_address};

  assign o_wr_ready     = ready_q;
  assign o_swap_pending = (state == PENDING);
  assign o_swap         = swap_now;

  sdp_ram #(.DEPTH(2 * ROWS * WIDTH), .WIDTH(PIXEL_W)) u_ram_top (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (accept && !wr_idx[IDX_W-1]),
    .i_wr_addr (wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (o_data0)
  );

  sdp_ram #(.DEPTH(2 * ROWS * WIDTH), .WIDTH(PIXEL_W)) u_ram_bot (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (accept && wr_idx[IDX_W-1]),
    .i_wr_addr (wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (o_data1)
  );

endmodule
